// File: rtl/mau_pkg.sv
// Shared definitions for the Matrix Acceleration Unit (MAU) float-to-fixed converter.
// Holds the internal float field widths and the converter state encoding.
package mau_pkg;

  localparam int unsigned MAU_MANT_W = 18;  // normalized mantissa, bit 17 weighs 1.0
  localparam int unsigned MAU_EXP_W  = 5;   // biased exponent

  typedef enum logic [1:0] {
    F2X_IDLE,
    F2X_SHIFT,
    F2X_FINISH
  } f2x_state_e;

endpackage

// File: rtl/mau_float_to_fixed_if.sv
// Start/done bus of the MAU float-to-fixed converter.
//   master: drives start, a_mantissa, a_exponent, a_sign; observes busy, done, result, saturated
//   slave : the converter side
interface mau_float_to_fixed_if #(
  parameter int unsigned OUT_W = 32
) ();
  import mau_pkg::*;

  logic                  start;
  logic [MAU_MANT_W-1:0] a_mantissa;
  logic [MAU_EXP_W-1:0]  a_exponent;
  logic                  a_sign;
  logic                  busy;
  logic                  done;
  logic [OUT_W-1:0]      result;
  logic                  saturated;

  modport master (
    output start, a_mantissa, a_exponent, a_sign,
    input  busy, done, result, saturated
  );

  modport slave (
    input  start, a_mantissa, a_exponent, a_sign,
    output busy, done, result, saturated
  );

endinterface

// File: rtl/mau_float_to_fixed.sv
// Iterative MAU float -> two's-complement fixed-point converter.
// One shift step per cycle; done pulses once per accepted start.
//   clk   : rising-edge clock
//   reset : asynchronous, active-low reset
//   bus   : slave side of mau_float_to_fixed_if (start/operands in, busy/done/result/saturated out)
module mau_float_to_fixed
  import mau_pkg::*;
#(
  parameter int unsigned OUT_W    = 32,
  parameter int unsigned FRAC_W   = 16,
  parameter int unsigned EXP_BIAS = 15
) (
  input logic                 clk,
  input logic                 reset,
  mau_float_to_fixed_if.slave bus
);

  localparam int unsigned CNT_W = 8;
  // Shift amount k = e + K_OFS; the mantissa's binary point sits at bit 17.
  localparam int K_OFS = int'(FRAC_W) - int'(EXP_BIAS) - int'(MAU_MANT_W - 1);
  localparam logic [OUT_W-1:0] MAX_POS = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic [OUT_W-1:0] MIN_NEG = {1'b1, {(OUT_W-1){1'b0}}};

  f2x_state_e       r_state;
  logic [OUT_W-1:0] r_work;
  logic [CNT_W-1:0] r_cnt;
  logic             r_left;
  logic             r_ovf;
  logic             r_sign;
  logic             r_done;
  logic             r_sat;
  logic [OUT_W-1:0] r_result;

  int   w_k;
  int   w_k_abs;
  logic w_pos_over;
  logic w_neg_over;

  always_comb begin
    w_k     = int'(bus.a_exponent) + K_OFS;
    w_k_abs = (w_k < 0) ? -w_k : w_k;
    // Positive limit is 2^(OUT_W-1)-1; negative limit is exactly 2^(OUT_W-1).
    w_pos_over = r_ovf | r_work[OUT_W-1];
    w_neg_over = r_ovf | (r_work[OUT_W-1] & (|r_work[OUT_W-2:0]));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= F2X_IDLE;
      r_work   <= '0;
      r_cnt    <= '0;
      r_left   <= 1'b0;
      r_ovf    <= 1'b0;
      r_sign   <= 1'b0;
      r_done   <= 1'b0;
      r_sat    <= 1'b0;
      r_result <= '0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        F2X_IDLE: begin
          if (bus.start) begin
            r_state <= F2X_SHIFT;
            r_sign  <= bus.a_sign;
            r_left  <= (w_k > 0);
            r_ovf   <= 1'b0;
            // Everything shifts out anyway; skip the iterations.
            if (w_k <= -int'(MAU_MANT_W)) begin
              r_work <= '0;
              r_cnt  <= '0;
            end else begin
              r_work <= OUT_W'(bus.a_mantissa);
              r_cnt  <= CNT_W'(w_k_abs);
            end
          end
        end
        F2X_SHIFT: begin
          if (r_cnt == '0) begin
            r_state <= F2X_FINISH;
          end else begin
            if (r_left) begin
              if (r_work[OUT_W-1]) r_ovf <= 1'b1;
              r_work <= r_work << 1;
            end else begin
              r_work <= r_work >> 1;  // truncation = round toward zero on the magnitude
            end
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        F2X_FINISH: begin
          r_state <= F2X_IDLE;
          r_done  <= 1'b1;
          if (!r_sign) begin
            r_sat    <= w_pos_over;
            r_result <= w_pos_over ? MAX_POS : r_work;
          end else begin
            r_sat    <= w_neg_over;
            r_result <= w_neg_over ? MIN_NEG : -r_work;
          end
        end
        default: r_state <= F2X_IDLE;
      endcase
    end
  end

  assign bus.busy      = (r_state != F2X_IDLE);
  assign bus.done      = r_done;
  assign bus.result    = r_result;
  assign bus.saturated = r_sat;

endmodule

// File: tb/tb_mau_float_to_fixed.sv
// Self-checking bench for mau_float_to_fixed with default parameters.
module tb_mau_float_to_fixed;
  import mau_pkg::*;

  localparam int unsigned OUT_W = 32;

  typedef struct {
    logic [17:0] mant;
    logic [4:0]  exp;
    logic        sign;
    logic [31:0] res;
    logic        sat;
    int          lat;
  } vec_t;

  typedef struct {
    logic [31:0] res;
    logic        sat;
  } exp_t;

  logic clk   = 1'b0;
  logic reset = 1'b0;

  mau_float_to_fixed_if #(.OUT_W(OUT_W)) bus ();

  mau_float_to_fixed #(
    .OUT_W   (OUT_W),
    .FRAC_W  (16),
    .EXP_BIAS(15)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  exp_t sb_q[$];
  int   checks   = 0;
  int   failures = 0;
  vec_t vecs[11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, req);
    end
  endtask

  function automatic vec_t mk(input logic [17:0] m, input logic [4:0] e, input logic s,
                              input logic [31:0] r, input logic sat, input int lat);
    vec_t v;
    v.mant = m; v.exp = e; v.sign = s; v.res = r; v.sat = sat; v.lat = lat;
    return v;
  endfunction

  // Scoreboard: every done pops one expected entry.
  always @(negedge clk) begin : mon
    exp_t e;
    if (reset && bus.done) begin
      if (sb_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done actual=1 required=0 result=0x%08h", bus.result);
      end else begin
        e = sb_q.pop_front();
        check("result", bus.result, e.res);
        check("saturated", 32'(bus.saturated), 32'(e.sat));
      end
    end
  end

  task automatic drive(input logic [17:0] m, input logic [4:0] e, input logic s);
    bus.a_mantissa = m;
    bus.a_exponent = e;
    bus.a_sign     = s;
    bus.start      = 1'b1;
  endtask

  task automatic push_exp(input logic [31:0] r, input logic sat);
    exp_t x;
    x.res = r;
    x.sat = sat;
    sb_q.push_back(x);
  endtask

  task automatic run_vec(input vec_t v, input string name);
    int lat;
    lat = -1;
    @(negedge clk);
    drive(v.mant, v.exp, v.sign);
    push_exp(v.res, v.sat);
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    check({name, "_busy"}, 32'(bus.busy), 32'd1);
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk);
      #1;
      if (bus.done) begin
        lat = c;
        break;
      end
    end
    check({name, "_latency"}, 32'(lat), 32'(v.lat));
  endtask

  initial begin
    int dones;
    logic [15:0] mask;

    vecs[0]  = mk(18'h20000, 5'd15, 1'b0, 32'h0001_0000, 1'b0, 3);
    vecs[1]  = mk(18'h3FFFF, 5'd0,  1'b0, 32'h0000_0003, 1'b0, 18);
    vecs[2]  = mk(18'h3FFFF, 5'd0,  1'b1, 32'hFFFF_FFFD, 1'b0, 18);
    vecs[3]  = mk(18'h3FFFF, 5'd31, 1'b0, 32'h7FFF_FFFF, 1'b1, 17);
    vecs[4]  = mk(18'h3FFFF, 5'd31, 1'b1, 32'h8000_0000, 1'b1, 17);
    vecs[5]  = mk(18'h20000, 5'd30, 1'b1, 32'h8000_0000, 1'b0, 16);
    vecs[6]  = mk(18'h20000, 5'd30, 1'b0, 32'h7FFF_FFFF, 1'b1, 16);
    vecs[7]  = mk(18'h00000, 5'd16, 1'b1, 32'h0000_0000, 1'b0, 2);
    vecs[8]  = mk(18'h30000, 5'd20, 1'b1, 32'hFFD0_0000, 1'b0, 6);
    vecs[9]  = mk(18'h2AAAA, 5'd10, 1'b1, 32'hFFFF_F556, 1'b0, 8);
    vecs[10] = mk(18'h2AAAA, 5'd10, 1'b0, 32'h0000_0AAA, 1'b0, 8);

    bus.start      = 1'b0;
    bus.a_mantissa = '0;
    bus.a_exponent = '0;
    bus.a_sign     = 1'b0;

    #1;
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_result", bus.result, 32'd0);
    check("rst_saturated", 32'(bus.saturated), 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < 11; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // start held high: one accept while busy, next accept in the done cycle.
    @(negedge clk);
    drive(18'h20000, 5'd15, 1'b0);
    push_exp(32'h0001_0000, 1'b0);
    push_exp(32'h0001_0000, 1'b0);
    mask = '0;
    @(posedge clk);
    for (int c = 1; c <= 10; c++) begin
      @(posedge clk);
      #1;
      if (bus.done) mask[c] = 1'b1;
      if (c == 3) check("held_busy_in_done", 32'(bus.busy), 32'd0);
      if (c == 4) begin
        check("held_busy_reaccept", 32'(bus.busy), 32'd1);
        bus.start = 1'b0;
      end
    end
    check("held_done_mask", 32'(mask), 32'h0000_0088);

    // Reset mid-conversion after a saturating result so every output has something to clear.
    run_vec(vecs[3], "pre_rst");
    @(negedge clk);
    drive(18'h3FFFF, 5'd0, 1'b0);
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    check("midrst_busy", 32'(bus.busy), 32'd0);
    check("midrst_done", 32'(bus.done), 32'd0);
    check("midrst_result", bus.result, 32'd0);
    check("midrst_saturated", 32'(bus.saturated), 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    dones = 0;
    for (int c = 0; c < 25; c++) begin
      @(posedge clk);
      #1;
      if (bus.done) dones++;
    end
    check("midrst_no_done", 32'(dones), 32'd0);
    run_vec(vecs[8], "post_rst");

    repeat (2) @(posedge clk);
    check("scoreboard_empty", 32'(sb_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
